bin_bcd_conv: RTL and testbench

BIN_BCD_CONV -- requirements
Module: bin_bcd_conv

---
 rtl/bin_bcd_conv.sv | 108 ++++++++++
 tb/tb_bin_bcd_conv.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bin_bcd_conv.sv
`default_nettype none
// ============================================================================
// bin_bcd_conv : sequential binary to 6-digit packed BCD (shift-add-3)
// Rev 1.0 : initial release
// ============================================================================
module bin_bcd_conv #(
  parameter int BIN_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [23:0]      bcd,
  output logic             ovf
);

  localparam int CNT_W = (BIN_W < 2) ? 1 : $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(BIN_W - 1);
  localparam logic [23:0] C_SAT = 24'h999999;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [BIN_W-1:0] r_sr;
  logic [23:0]      r_scr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf_pend;
  logic [23:0]      w_adj;
  logic [23:0]      w_scr_nxt;
  logic             w_last;
  logic             w_ovf_fin;

  for (genvar i = 0; i < 6; i++) begin : g_adj
    assign w_adj[4*i +: 4] = (r_scr[4*i +: 4] >= 4'd5) ? r_scr[4*i +: 4] + 4'd3
                                                        : r_scr[4*i +: 4];
  end

  assign w_scr_nxt = {w_adj[22:0], r_sr[BIN_W-1]};
  assign w_last    = (r_cnt == C_LAST);
  // Any bit pushed past the sixth digit means the value needs a seventh digit.
  assign w_ovf_fin = r_ovf_pend | w_adj[23];

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_CONV;
      S_CONV: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sr       <= '0;
      r_scr      <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      bcd        <= '0;
      ovf        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sr       <= bin;
            r_scr      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
          end
        end
        S_CONV: begin
          r_sr       <= r_sr << 1;
          r_scr      <= w_scr_nxt;
          r_cnt      <= r_cnt + 1'b1;
          r_ovf_pend <= w_ovf_fin;
          if (w_last) begin
            bcd <= w_ovf_fin ? C_SAT : w_scr_nxt;
            ovf <= w_ovf_fin;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bin_bcd_conv.sv
`default_nettype none
// ============================================================================
// tb_bin_bcd_conv : scoreboard bench for bin_bcd_conv (BIN_W=20 and BIN_W=4)
// Rev 1.0 : initial release
// ============================================================================
module tb_bin_bcd_conv;

  localparam int BIN_W = 20;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [BIN_W-1:0] bin   = '0;
  logic             busy, done, ovf;
  logic [23:0]      bcd;

  logic             start4 = 1'b0;
  logic [3:0]       bin4   = '0;
  logic             busy4, done4, ovf4;
  logic [23:0]      bcd4;

  always #5 clk = ~clk;

  bin_bcd_conv #(.BIN_W(BIN_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .ovf(ovf)
  );

  bin_bcd_conv #(.BIN_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .bin(bin4),
    .busy(busy4), .done(done4), .bcd(bcd4), .ovf(ovf4)
  );

  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  logic [24:0] exp_q[$];
  int          acc_q[$];
  int          m_left = 0;
  logic [23:0] m_bcd  = '0;
  logic        m_ovf  = 1'b0;
  bit          hold_mode = 1'b0;
  int          last_done = -1;

  // Decimal digits by repeated division; saturate above six digits.
  function automatic logic [24:0] ref_model(input int unsigned v);
    logic [23:0] r;
    int unsigned t;
    if (v > 999999) return {24'h999999, 1'b1};
    r = '0;
    t = v;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return {r, 1'b0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Acceptance/busy model: a start seen while idle begins a BIN_W+1 cycle busy window.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_left = 0;
      exp_q.delete();
      acc_q.delete();
      m_bcd = '0;
      m_ovf = 1'b0;
    end else if (m_left == 0) begin
      if (start) begin
        exp_q.push_back(ref_model(32'(bin)));
        acc_q.push_back(cyc);
        m_left = BIN_W + 1;
      end
    end else begin
      m_left--;
    end
  end

  always @(negedge clk) begin
    logic [24:0] e;
    int          a;
    logic        bad_digit;
    check("busy", 32'(busy), 32'(m_left != 0));
    check("done", 32'(done), 32'(m_left == 1));
    bad_digit = 1'b0;
    for (int i = 0; i < 6; i++) if (bcd[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    check("digit_range", 32'(bad_digit), 32'd0);
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending conversion at cycle %0d", cyc);
      end else begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        check("bcd", 32'(bcd), 32'(e[24:1]));
        check("ovf", 32'(ovf), 32'(e[0]));
        check("latency", 32'(cyc - a), 32'(BIN_W));
        if (hold_mode && last_done >= 0) check("hold_spacing", 32'(cyc - last_done), 32'(BIN_W + 2));
        last_done = cyc;
        m_bcd = e[24:1];
        m_ovf = e[0];
      end
    end else begin
      check("bcd_hold", 32'(bcd), 32'(m_bcd));
      check("ovf_hold", 32'(ovf), 32'(m_ovf));
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (m_left != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (m_left != 0) begin
      checks++;
      errors++;
      $display("FAIL idle_wait: got busy after %0d cycles expected idle", n);
    end
  endtask

  task automatic conv(input logic [BIN_W-1:0] v);
    wait_idle();
    start = 1'b1;
    bin   = v;
    @(negedge clk);
    start = 1'b0;
    bin   = BIN_W'($urandom);
  endtask

  task automatic conv4(input logic [3:0] v);
    logic [24:0] e;
    int          c0;
    int          n;
    start4 = 1'b1;
    bin4   = v;
    @(negedge clk);
    start4 = 1'b0;
    bin4   = 4'($urandom);
    c0 = cyc;
    check("busy4_accept", 32'(busy4), 32'd1);
    n = 0;
    while (done4 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    e = ref_model(32'(v));
    check("latency4", 32'(cyc - c0), 32'd4);
    check("bcd4", 32'(bcd4), 32'(e[24:1]));
    check("ovf4", 32'(ovf4), 32'(e[0]));
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    start = 1'b1;
    bin   = 20'd55;
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_bcd", 32'(bcd), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);

    conv(20'd123456);
    check("busy_after_accept", 32'(busy), 32'd1);
    conv(20'd999999);
    conv(20'hFFFFF);
    conv(20'd0);
    conv(20'd1);
    conv(20'd9);
    conv(20'd10);
    conv(20'd1000000);
    conv(20'd500000);

    conv(20'd42);
    conv(20'd777);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_bcd", 32'(bcd), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    conv(20'd31415);

    for (int k = 0; k < 150; k++) begin
      if (k % 3 == 0) conv(20'($urandom_range(999980, 1000020)));
      else            conv(20'($urandom_range(0, 20'hFFFFF)));
    end

    wait_idle();
    hold_mode = 1'b1;
    last_done = -1;
    start     = 1'b1;
    for (int k = 1; k <= 5 * (BIN_W + 2); k++) begin
      bin = BIN_W'(k);
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle();
    hold_mode = 1'b0;

    conv4(4'd15);
    conv4(4'd0);
    conv4(4'd7);
    conv4(4'd10);

    wait_idle();
    repeat (2) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
